assoc_data_array: RTL

Parametrised N-way set-associative tag/data/state store for the L1 cache datapath, the successor to the direct-mapped array. Holds per-way tag, valid and dirty bits plus line data. Serves word reads, byte-enabled word writes, line fills and victim evictions through one valid/ready request port and a single-cycle response pulse. Victim selection uses true LRU or round-robin, chosen at compile time.

---
 rtl/assoc_data_array.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/assoc_data_array.sv
// ============================================================================
// Module      : assoc_data_array
// Description : N-way set-associative tag/data/state store with word reads,
//               byte-enabled writes, line fills and evictions. The victim
//               policy is selected by ASSOC_ARRAY_LRU_EN: true LRU when the
//               macro is defined, otherwise a per-set round-robin pointer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module assoc_data_array #(
  parameter int unsigned LINE_SIZE  = 64,
  parameter int unsigned NUM_SETS   = 64,
  parameter int unsigned WAYS       = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = ADDR_WIDTH - $clog2(NUM_SETS) - $clog2(LINE_SIZE)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [1:0]                   req_op_i,
  input  logic [$clog2(NUM_SETS)-1:0]  req_index_i,
  input  logic [TAG_WIDTH-1:0]         req_tag_i,
  input  logic [$clog2(LINE_SIZE)-1:0] req_offset_i,
  input  logic [$clog2(WAYS)-1:0]      req_way_i,
  input  logic [DATA_WIDTH-1:0]        req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]      req_be_i,
  input  logic [LINE_SIZE*8-1:0]       req_line_i,
  output logic                         resp_valid_o,
  output logic                         resp_hit_o,
  output logic [$clog2(WAYS)-1:0]      resp_way_o,
  output logic                         resp_dirty_o,
  output logic [TAG_WIDTH-1:0]         resp_victim_tag_o,
  output logic [DATA_WIDTH-1:0]        resp_rdata_o,
  output logic [LINE_SIZE*8-1:0]       resp_line_o
);

  localparam int c_idx_w  = $clog2(NUM_SETS);
  localparam int c_off_w  = $clog2(LINE_SIZE);
  localparam int c_way_w  = $clog2(WAYS);
  localparam int c_bytes  = DATA_WIDTH / 8;
  localparam int c_bsel_w = $clog2(c_bytes);
  localparam int c_wsel_w = c_off_w - c_bsel_w;
  localparam int c_line_w = LINE_SIZE * 8;

  localparam logic [1:0] c_OP_READ  = 2'd0;
  localparam logic [1:0] c_OP_WRITE = 2'd1;
  localparam logic [1:0] c_OP_FILL  = 2'd2;
  localparam logic [1:0] c_OP_EVICT = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e state_q;

  logic [c_line_w-1:0]  data_q  [NUM_SETS][WAYS];
  logic [TAG_WIDTH-1:0] tags_q  [NUM_SETS][WAYS];
  logic [WAYS-1:0]      valid_q [NUM_SETS];
  logic [WAYS-1:0]      dirty_q [NUM_SETS];

  logic [1:0]            op_q;
  logic [c_idx_w-1:0]    idx_q;
  logic [TAG_WIDTH-1:0]  rtag_q;
  logic [c_wsel_w-1:0]   word_q;
  logic [c_way_w-1:0]    way_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [c_bytes-1:0]    be_q;
  logic [c_line_w-1:0]   line_q;

  logic                  resp_valid_q, resp_hit_q, resp_dirty_q;
  logic [c_way_w-1:0]    resp_way_q;
  logic [TAG_WIDTH-1:0]  resp_vtag_q;
  logic [DATA_WIDTH-1:0] resp_rdata_q;
  logic [c_line_w-1:0]   resp_line_q;

  logic                  w_unused_offset;
  logic [WAYS-1:0]       w_set_valid;
  logic [WAYS-1:0]       w_match;
  logic                  w_hit;
  logic [c_way_w-1:0]    w_hit_way;
  logic [c_way_w-1:0]    w_repl_victim;
  logic [c_way_w-1:0]    w_victim;
  logic [c_way_w-1:0]    w_resp_way;
  logic [c_way_w-1:0]    w_touch_way;
  logic                  w_touch_en;
  logic [c_line_w-1:0]   w_hit_line;
  logic [c_line_w-1:0]   w_wline;
  logic [DATA_WIDTH-1:0] w_rword;

  assign w_unused_offset = ^req_offset_i[c_bsel_w-1:0];

  assign req_ready_o       = (state_q == S_IDLE);
  assign resp_valid_o      = resp_valid_q;
  assign resp_hit_o        = resp_hit_q;
  assign resp_way_o        = resp_way_q;
  assign resp_dirty_o      = resp_dirty_q;
  assign resp_victim_tag_o = resp_vtag_q;
  assign resp_rdata_o      = resp_rdata_q;
  assign resp_line_o       = resp_line_q;

  // Descending scans so the lowest-index matching / invalid way wins.
  always_comb begin
    w_set_valid = valid_q[idx_q];
    w_match     = '0;
    w_hit_way   = '0;
    w_victim    = w_repl_victim;
    for (int w = 0; w < WAYS; w++) begin
      w_match[w] = w_set_valid[w] && (tags_q[idx_q][w] == rtag_q);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (w_match[w])     w_hit_way = c_way_w'(w);
      if (!w_set_valid[w]) w_victim = c_way_w'(w);
    end
    w_hit = |w_match;

    if (op_q == c_OP_FILL || op_q == c_OP_EVICT) w_resp_way = way_q;
    else if (w_hit)                              w_resp_way = w_hit_way;
    else                                         w_resp_way = w_victim;

    w_touch_way = (op_q == c_OP_FILL) ? way_q : w_hit_way;
    w_touch_en  = (op_q == c_OP_FILL) ||
                  ((op_q == c_OP_READ || op_q == c_OP_WRITE) && w_hit);

    w_hit_line = data_q[idx_q][w_hit_way];
    w_rword    = w_hit_line[int'(word_q)*DATA_WIDTH +: DATA_WIDTH];
    w_wline    = w_hit_line;
    for (int b = 0; b < c_bytes; b++) begin
      if (be_q[b]) w_wline[(int'(word_q)*c_bytes + b)*8 +: 8] = wdata_q[b*8 +: 8];
    end
  end

`ifdef ASSOC_ARRAY_LRU_EN
  logic [c_way_w-1:0] age_q [NUM_SETS][WAYS];

  always_comb begin
    w_repl_victim = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (age_q[idx_q][w] == c_way_w'(WAYS - 1)) w_repl_victim = c_way_w'(w);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= c_way_w'(w);
    end else if (state_q == S_LOOKUP && w_touch_en) begin
      for (int w = 0; w < WAYS; w++) begin
        if (c_way_w'(w) == w_touch_way)
          age_q[idx_q][w] <= '0;
        else if (age_q[idx_q][w] < age_q[idx_q][w_touch_way])
          age_q[idx_q][w] <= age_q[idx_q][w] + 1'b1;
      end
    end
  end
`else
  logic [c_way_w-1:0] rr_q [NUM_SETS];

  assign w_repl_victim = rr_q[idx_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) rr_q[s] <= '0;
    end else if (state_q == S_LOOKUP && op_q == c_OP_FILL) begin
      rr_q[idx_q] <= rr_q[idx_q] + 1'b1;
    end
  end
`endif

  // Request capture and line/tag storage carry no reset.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && req_valid_i) begin
      op_q    <= req_op_i;
      idx_q   <= req_index_i;
      rtag_q  <= req_tag_i;
      word_q  <= req_offset_i[c_off_w-1:c_bsel_w];
      way_q   <= req_way_i;
      wdata_q <= req_wdata_i;
      be_q    <= req_be_i;
      line_q  <= req_line_i;
    end
    if (rst_n && state_q == S_LOOKUP) begin
      if (op_q == c_OP_WRITE && w_hit) data_q[idx_q][w_hit_way] <= w_wline;
      if (op_q == c_OP_FILL) begin
        data_q[idx_q][way_q] <= line_q;
        tags_q[idx_q][way_q] <= rtag_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_way_q   <= '0;
      resp_dirty_q <= 1'b0;
      resp_vtag_q  <= '0;
      resp_rdata_q <= '0;
      resp_line_q  <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) state_q <= S_LOOKUP;
        end
        S_LOOKUP: begin
          state_q      <= S_RESP;
          resp_valid_q <= 1'b1;
          resp_hit_q   <= (op_q == c_OP_FILL) ? 1'b1 : w_hit;
          resp_way_q   <= w_resp_way;
          resp_dirty_q <= dirty_q[idx_q][w_resp_way];
          resp_vtag_q  <= tags_q[idx_q][w_resp_way];
          resp_rdata_q <= (op_q == c_OP_READ && w_hit) ? w_rword : '0;
          resp_line_q  <= (op_q == c_OP_EVICT) ? data_q[idx_q][way_q] : '0;
          case (op_q)
            c_OP_WRITE: begin
              if (w_hit) dirty_q[idx_q][w_hit_way] <= 1'b1;
            end
            c_OP_FILL: begin
              // A fill must leave at most one valid copy of a tag per set.
              for (int w = 0; w < WAYS; w++) begin
                if (w_match[w] && c_way_w'(w) != way_q) begin
                  valid_q[idx_q][w] <= 1'b0;
                  dirty_q[idx_q][w] <= 1'b0;
                end
              end
              valid_q[idx_q][way_q] <= 1'b1;
              dirty_q[idx_q][way_q] <= 1'b0;
            end
            c_OP_EVICT: begin
              valid_q[idx_q][way_q] <= 1'b0;
              dirty_q[idx_q][way_q] <= 1'b0;
            end
            default: ;
          endcase
        end
        S_RESP: begin
          state_q      <= S_IDLE;
          resp_valid_q <= 1'b0;
          resp_hit_q   <= 1'b0;
          resp_way_q   <= '0;
          resp_dirty_q <= 1'b0;
          resp_vtag_q  <= '0;
          resp_rdata_q <= '0;
          resp_line_q  <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
